// File: rtl/uart_pkg.sv
// Shared UART-side types: parser FSM states, frame error codes and the default SOF marker.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_LEN     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CHK     = 3'd4
   } parser_state_e;

   typedef enum logic [1:0] {
      ERR_CHK     = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_LINE    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } parser_err_e;

   localparam logic [7:0] UART_SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_parser.sv
// Frame parser SOF,CMD,LEN,payload[LEN],CHK behind the UART receiver; payload streams speculatively.
// Optional inter-byte timeout enabled by defining UART_PARSER_TIMEOUT_EN.
module uart_cmd_parser
   import uart_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE    = UART_SOF_DEFAULT,
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   input  logic       in_error,
   output logic [7:0] cmd,
   output logic [7:0] len,
   output logic       pl_valid,
   output logic [7:0] pl_data,
   output logic [7:0] pl_idx,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   parser_state_e state, state_nxt;
   logic [7:0]    chk, chk_nxt, cnt, cnt_nxt;
   logic [7:0]    cmd_nxt, len_nxt, pl_data_nxt, pl_idx_nxt;
   logic          pl_valid_nxt, frame_ok_nxt, frame_err_nxt;
   parser_err_e   code_nxt;
   logic          timeout;

`ifdef UART_PARSER_TIMEOUT_EN
   logic [31:0] gap_cnt;

   assign timeout = (state != ST_IDLE) && !in_valid && !in_error &&
                    (gap_cnt == 32'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst)
         gap_cnt <= '0;
      else if (in_valid || state_nxt == ST_IDLE)
         gap_cnt <= '0;
      else if (state != ST_IDLE)
         gap_cnt <= gap_cnt + 32'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign timeout        = 1'b0;
`endif

   always_comb begin
      state_nxt     = state;
      chk_nxt       = chk;
      cnt_nxt       = cnt;
      cmd_nxt       = cmd;
      len_nxt       = len;
      pl_valid_nxt  = 1'b0;
      pl_data_nxt   = pl_data;
      pl_idx_nxt    = pl_idx;
      frame_ok_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      code_nxt      = parser_err_e'(err_code);
      // A line error mid-frame outranks a byte arriving in the same cycle
      if (state != ST_IDLE && in_error) begin
         frame_err_nxt = 1'b1;
         code_nxt      = ERR_LINE;
         state_nxt     = ST_IDLE;
      end else if (in_valid) begin
         case (state)
            ST_IDLE: if (in_byte == SOF_BYTE) state_nxt = ST_CMD;
            ST_CMD: begin
               cmd_nxt   = in_byte;
               chk_nxt   = in_byte;
               state_nxt = ST_LEN;
            end
            ST_LEN: begin
               len_nxt = in_byte;
               chk_nxt = chk ^ in_byte;
               cnt_nxt = 8'd0;
               if (in_byte > MAX_LEN_B) begin
                  frame_err_nxt = 1'b1;
                  code_nxt      = ERR_LEN;
                  state_nxt     = ST_IDLE;
               end else if (in_byte == 8'd0) begin
                  state_nxt = ST_CHK;
               end else begin
                  state_nxt = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               pl_valid_nxt = 1'b1;
               pl_data_nxt  = in_byte;
               pl_idx_nxt   = cnt;
               chk_nxt      = chk ^ in_byte;
               cnt_nxt      = cnt + 8'd1;
               if (cnt == len - 8'd1) state_nxt = ST_CHK;
            end
            ST_CHK: begin
               if (in_byte == chk) begin
                  frame_ok_nxt = 1'b1;
               end else begin
                  frame_err_nxt = 1'b1;
                  code_nxt      = ERR_CHK;
               end
               state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if (timeout) begin
         frame_err_nxt = 1'b1;
         code_nxt      = ERR_TIMEOUT;
         state_nxt     = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         chk       <= 8'd0;
         cnt       <= 8'd0;
         cmd       <= 8'd0;
         len       <= 8'd0;
         pl_valid  <= 1'b0;
         pl_data   <= 8'd0;
         pl_idx    <= 8'd0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'd0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         chk       <= chk_nxt;
         cnt       <= cnt_nxt;
         cmd       <= cmd_nxt;
         len       <= len_nxt;
         pl_valid  <= pl_valid_nxt;
         pl_data   <= pl_data_nxt;
         pl_idx    <= pl_idx_nxt;
         frame_ok  <= frame_ok_nxt;
         frame_err <= frame_err_nxt;
         err_code  <= code_nxt;
         busy      <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame-level reference model, directed and random frames.
module tb_uart_cmd_parser;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_error;
   logic [7:0] in_byte;
   logic [7:0] cmd, len, pl_data, pl_idx;
   logic       pl_valid, frame_ok, frame_err, busy;
   logic [1:0] err_code;

   int n_cmp = 0;
   int n_bad = 0;

   logic       e_pv, e_ok, e_err, e_busy;
   logic [7:0] e_pd, e_pi, e_cmd, e_len;
   logic [1:0] e_code;

   uart_cmd_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(50)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_error(in_error),
      .cmd(cmd), .len(len), .pl_valid(pl_valid), .pl_data(pl_data), .pl_idx(pl_idx),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      cmp({tag, ".pl_valid"},  32'(pl_valid),  32'(e_pv));
      cmp({tag, ".frame_ok"},  32'(frame_ok),  32'(e_ok));
      cmp({tag, ".frame_err"}, 32'(frame_err), 32'(e_err));
      cmp({tag, ".busy"},      32'(busy),      32'(e_busy));
      cmp({tag, ".err_code"},  32'(err_code),  32'(e_code));
      cmp({tag, ".cmd"},       32'(cmd),       32'(e_cmd));
      cmp({tag, ".len"},       32'(len),       32'(e_len));
      if (e_pv) begin
         cmp({tag, ".pl_data"}, 32'(pl_data), 32'(e_pd));
         cmp({tag, ".pl_idx"},  32'(pl_idx),  32'(e_pi));
      end
   endtask

   task automatic quiet();
      e_pv = 1'b0; e_ok = 1'b0; e_err = 1'b0;
   endtask

   // Drive one cycle of inputs from a negedge, check registered response at the next negedge
   task automatic step(input logic v, input logic e, input logic [7:0] b, input string tag);
      in_valid = v; in_error = e; in_byte = b;
      @(negedge clk);
      in_valid = 1'b0; in_error = 1'b0;
      check_all(tag);
   endtask

   // Frame-level model: builds the byte list, then states the response each byte must produce
   task automatic run_frame(input logic [7:0] c, input logic [7:0] l, input bit fixed,
                            input bit corrupt, input int err_pos, input int max_gap);
      logic [7:0] bytes[$];
      logic [7:0] x, p;
      int         last;
      bytes.push_back(8'hA5);
      bytes.push_back(c);
      bytes.push_back(l);
      x = c ^ l;
      if (l <= 8'd16) begin
         for (int i = 0; i < int'(l); i++) begin
            p = fixed ? 8'((i + 1) * 8'h11) : 8'($urandom);
            bytes.push_back(p);
            x = x ^ p;
         end
         bytes.push_back(corrupt ? (x ^ 8'h01) : x);
      end
      last = bytes.size() - 1;
      for (int k = 0; k <= last; k++) begin
         repeat ($urandom_range(max_gap, 0)) begin
            quiet();
            step(1'b0, 1'b0, 8'h00, "gap");
         end
         quiet();
         if (k == err_pos) begin
            e_err = 1'b1; e_code = 2'd2; e_busy = 1'b0;
            step(1'b1, 1'b1, bytes[k], "line_err");
            quiet();
            step(1'b0, 1'b0, 8'h00, "after_line_err");
            return;
         end
         if (k == 0) e_busy = 1'b1;
         else if (k == 1) e_cmd = c;
         else if (k == 2) begin
            e_len = l;
            if (l > 8'd16) begin
               e_err = 1'b1; e_code = 2'd1; e_busy = 1'b0;
            end
         end
         if (k > 2 && k < last) begin
            e_pv = 1'b1; e_pd = bytes[k]; e_pi = 8'(k - 3);
         end else if (k > 2 && k == last) begin
            e_busy = 1'b0;
            if (corrupt) begin
               e_err = 1'b1; e_code = 2'd0;
            end else begin
               e_ok = 1'b1;
            end
         end
         step(1'b1, 1'b0, bytes[k], "frame");
      end
      quiet();
      step(1'b0, 1'b0, 8'h00, "post_frame");
   endtask

   initial begin
      logic [7:0] nb, rl;
      bit         rc;
      int         ep;
      rst = 1'b1; in_valid = 1'b0; in_error = 1'b0; in_byte = 8'h00;
      e_pv = 0; e_ok = 0; e_err = 0; e_busy = 0; e_pd = 0; e_pi = 0;
      e_cmd = 0; e_len = 0; e_code = 0;
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      run_frame(8'h10, 8'd3, 1'b1, 1'b0, -1, 0);
      run_frame(8'h10, 8'd3, 1'b1, 1'b1, -1, 0);
      run_frame(8'h01, 8'd0, 1'b0, 1'b0, -1, 0);
      run_frame(8'h20, 8'h11, 1'b0, 1'b0, -1, 0);
      quiet();
      step(1'b1, 1'b0, 8'h55, "noise_55");
      run_frame(8'h42, 8'd16, 1'b0, 1'b0, -1, 1);
      run_frame(8'h07, 8'd3, 1'b0, 1'b0, 4, 0);
      quiet();
      step(1'b0, 1'b1, 8'h00, "idle_in_error");
      run_frame(8'hA5, 8'd2, 1'b0, 1'b0, -1, 0);

`ifdef UART_PARSER_TIMEOUT_EN
      quiet(); e_busy = 1'b1;
      step(1'b1, 1'b0, 8'hA5, "to_sof");
      e_cmd = 8'h10;
      step(1'b1, 1'b0, 8'h10, "to_cmd");
      repeat (49) step(1'b0, 1'b0, 8'h00, "to_wait");
      e_err = 1'b1; e_code = 2'd3; e_busy = 1'b0;
      step(1'b0, 1'b0, 8'h00, "to_fire");
      quiet();
      step(1'b0, 1'b0, 8'h00, "to_after");
      e_busy = 1'b1;
      step(1'b1, 1'b0, 8'hA5, "to2_sof");
      step(1'b1, 1'b0, 8'h10, "to2_cmd");
      repeat (49) step(1'b0, 1'b0, 8'h00, "to2_wait");
      e_len = 8'h00;
      step(1'b1, 1'b0, 8'h00, "to2_late_len");
      e_ok = 1'b1; e_busy = 1'b0;
      step(1'b1, 1'b0, 8'h10, "to2_chk");
      quiet();
      step(1'b0, 1'b0, 8'h00, "to2_after");
`else
      quiet(); e_busy = 1'b1;
      step(1'b1, 1'b0, 8'hA5, "wait_sof");
      e_cmd = 8'h10;
      step(1'b1, 1'b0, 8'h10, "wait_cmd");
      repeat (200) step(1'b0, 1'b0, 8'h00, "wait_silence");
      e_len = 8'h00;
      step(1'b1, 1'b0, 8'h00, "wait_len");
      e_ok = 1'b1; e_busy = 1'b0;
      step(1'b1, 1'b0, 8'h10, "wait_chk");
      quiet();
      step(1'b0, 1'b0, 8'h00, "wait_after");
`endif

      // Reset mid-payload clears everything; next frame runs back-to-back
      quiet(); e_busy = 1'b1;
      step(1'b1, 1'b0, 8'hA5, "rst_sof");
      e_cmd = 8'h33;
      step(1'b1, 1'b0, 8'h33, "rst_cmd");
      e_len = 8'd4;
      step(1'b1, 1'b0, 8'd4, "rst_len");
      e_pv = 1'b1; e_pd = 8'h9C; e_pi = 8'd0;
      step(1'b1, 1'b0, 8'h9C, "rst_pl0");
      rst = 1'b1;
      quiet(); e_busy = 0; e_cmd = 0; e_len = 0; e_code = 0;
      step(1'b1, 1'b0, 8'h44, "rst_mid");
      rst = 1'b0;
      run_frame(8'h5A, 8'd5, 1'b0, 1'b0, -1, 0);

      for (int it = 0; it < 60; it++) begin
         repeat ($urandom_range(2, 0)) begin
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h00;
            quiet();
            step(1'b1, 1'b0, nb, "rnd_noise");
         end
         rl = 8'($urandom_range(20, 0));
         rc = ($urandom_range(3, 0) == 0);
         ep = ($urandom_range(7, 0) == 0) ?
              int'($urandom_range((rl > 8'd16) ? 2 : int'(rl) + 3, 1)) : -1;
         run_frame(8'($urandom), rl, 1'b0, rc, ep, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame parser downstream of the UART receiver. It consumes the receiver's one-cycle `received` strobe and byte, then extracts framed commands of the form SOF, CMD, LEN, payload[LEN], CHK. Payload bytes stream out as they arrive. Each frame ends with exactly one `frame_ok` or `frame_err` pulse, which the command-execution logic downstream acts on.

## Interface
Parameters:
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.
- `MAX_LEN`, default 16: largest legal LEN value, range 1..255.
- `TIMEOUT_CYC`, default 100000: allowed inter-byte gap in clk cycles inside a frame, must be ≥2.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: one-cycle strobe, byte available (UART `received`).
- `in_byte` in 8: received byte, sampled only when `in_valid`=1.
- `in_error` in 1: one-cycle UART framing-error strobe (`recv_error`).
- `cmd` out 8: CMD byte of the current/last frame, held until the next CMD byte.
- `len` out 8: LEN byte of the current/last frame, held.
- `pl_valid` out 1: one-cycle strobe, payload byte on `pl_data`.
- `pl_data` out 8: payload byte.
- `pl_idx` out 8: index 0..LEN-1 of `pl_data`.
- `frame_ok` out 1: one-cycle strobe, checksum matched.
- `frame_err` out 1: one-cycle strobe, frame aborted.
- `err_code` out 2: 0 CHK mismatch, 1 LEN>MAX_LEN, 2 line error, 3 timeout. Valid with `frame_err`, held after.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, CMD, LEN, PAYLOAD, CHK.
- IDLE:
  - `in_valid` with `in_byte`==SOF_BYTE → CMD.
  - Any other byte is dropped silently.
  - `in_error` is ignored.
- CMD: byte → `cmd`, chk=byte → LEN.
- LEN: byte → `len`, chk^=byte, cnt=0.
  - Byte > MAX_LEN → `frame_err`, code 1 → IDLE.
  - Byte == 0 → CHK.
  - Otherwise → PAYLOAD.
- PAYLOAD: each byte drives `pl_valid`/`pl_data`/`pl_idx`=cnt, chk^=byte, cnt++. After byte LEN-1 → CHK.
- CHK:
  - Byte == chk → `frame_ok`.
  - Otherwise → `frame_err`, code 0.
  - Either way → IDLE.
- Checksum is the 8-bit XOR of CMD, LEN and all payload bytes; SOF is excluded.
- `in_error` in any non-IDLE state → `frame_err`, code 2 → IDLE. If `in_valid` arrives in the same cycle, error wins and the byte is dropped.
- A SOF_BYTE value inside CMD/LEN/PAYLOAD/CHK is ordinary data; there is no resync.
- Payload is speculative: downstream must discard already-streamed bytes on `frame_err`.
- `rst` mid-frame returns to IDLE next edge. No error pulse is generated; the partial frame is lost.

## Timing
- All outputs are registered.
- Every response (`pl_valid`, `frame_ok`, `frame_err`, state change) appears on the cycle after the accepting `in_valid`/`in_error` edge: latency 1.
- At most one of `pl_valid`, `frame_ok`, `frame_err` is high in any cycle.
- Back-to-back `in_valid` on consecutive cycles must be accepted with no loss. The parser never stalls and has no ready signal.
- A new SOF accepted on the cycle after the `frame_ok`/`frame_err` edge (state already IDLE) must start a new frame.
- Reset values: `cmd`, `len`, `pl_data`, `pl_idx`, `err_code` = 0; `pl_valid`, `frame_ok`, `frame_err`, `busy` = 0; state IDLE, chk=0, cnt=0.

## Configuration
- `UART_PARSER_TIMEOUT_EN` defined:
  - A gap counter clears on every accepted byte and on entry to IDLE, and counts while not IDLE.
  - When it reaches TIMEOUT_CYC-1 with no `in_valid`/`in_error` that cycle → `frame_err`, code 3 → IDLE.
  - A byte arriving on the expiry cycle is accepted; the timeout does not fire.
- Undefined: the counter is not instantiated, code 3 is never produced, and the parser waits indefinitely mid-frame.

## Structure
- Shared package `uart_pkg` holds:
  - the parser state enum (`parser_state_e`),
  - the error-code enum (`parser_err_e`, 2 bits),
  - the default SOF constant.
- Single module, no sub-module.
- The timeout counter is inline logic, guarded by the macro.

## Test plan
- Byte stream A5,10,03,11,22,33,CHK=10^03^11^22^33=0x13 → three `pl_valid` (11/0, 22/1, 33/2), then `frame_ok`; `cmd`=0x10, `len`=3.
- Same frame with CHK=0x14 → payload strobes, then `frame_err` code 0; next frame A5,01,00,01 → `frame_ok`, no `pl_valid`.
- A5,20,11 (MAX_LEN=16) → `frame_err` code 1 one cycle after the LEN byte; a following 55,A5,… is parsed normally with 55 ignored.
- `in_error` pulsed with `in_valid` during PAYLOAD idx 1 → `frame_err` code 2, byte dropped, `busy`=0 next cycle.
- With `UART_PARSER_TIMEOUT_EN`, TIMEOUT_CYC=50: A5,10, then silence → `frame_err` code 3 exactly 50 cycles after the CMD byte's accept edge. A byte at cycle 49 → no timeout.
- Assert `rst` mid-payload → all outputs 0, IDLE. Back-to-back bytes on consecutive cycles after reset → a full frame is accepted with no loss.
